serial_frame_rx: RTL and testbench

- Parametrised successor to the processor's bit-serial command receiver.
- Synchronises an external serial clock/data pair into the processor clock domain and frames MSB-first opcode+payload messages using a per-opcode length table.
- Publishes the last payload and a status word (toggle, opcode, error flags) for memory-mapped register reads, e.g. r26 and r27.
- Adds an inter-bit timeout resync, unknown-opcode rejection and a frame-valid pulse.

---
 rtl/serial_frame_rx_if.sv | 24 ++
 rtl/serial_frame_rx.sv | 255 +++++++++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Serial receiver pin/register bundle. The slave modport is the receiver view; the master
// modport is the view of whatever drives the pins and reads the registers.
interface serial_frame_rx_if #(
  parameter int unsigned DATA_W = 27
);
  logic              ser_data_in;
  logic              ser_clock_in;
  logic              ser_data_thru;
  logic              ser_clock_thru;
  logic [DATA_W-1:0] data_out;
  logic [31:0]       status_out;
  logic              frame_valid;
  logic              err_clear;

  modport master (
    output ser_data_in, ser_clock_in, err_clear,
    input  ser_data_thru, ser_clock_thru, data_out, status_out, frame_valid
  );

  modport slave (
    input  ser_data_in, ser_clock_in, err_clear,
    output ser_data_thru, ser_clock_thru, data_out, status_out, frame_valid
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Bit-serial command receiver. Synchronises an external serial clock/data pair, frames
// MSB-first opcode+payload messages using a per-opcode length table and publishes the last
// payload plus a status word (toggle, opcode, sticky error flags).
// Optional feature macro: SERIAL_RX_PARITY_EN (adds a trailing even-parity bit per frame).
// OPCODE_W must be >= 2 and every LEN_TABLE entry <= DATA_W; TIMEOUT_CYC must be >= 2.
module serial_frame_rx #(
  parameter int unsigned                OPCODE_W    = 4,
  parameter int unsigned                DATA_W      = 27,
  parameter logic [(8<<OPCODE_W)-1:0]   LEN_TABLE   = 128'h0F,
  parameter logic [(1<<OPCODE_W)-1:0]   VALID_MASK  = 16'h0003,
  parameter int unsigned                TIMEOUT_CYC = 1024
) (
  input logic              clock,
  input logic              reset,
  serial_frame_rx_if.slave bus
);

  localparam int unsigned CntMax = (DATA_W > OPCODE_W) ? DATA_W : OPCODE_W;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned ToW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    StIdle,
    StOpcode,
    StPayload,
    StDrain,
    StCommit
`ifdef SERIAL_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          sclk_q;
  logic [1:0]          sdat_q;
  logic [OPCODE_W-1:0] op_q, op_d, stat_op_q, stat_op_d;
  logic [DATA_W-1:0]   pay_q, pay_d, data_q, data_d;
  logic [7:0]          len_q, len_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ToW-1:0]      to_q, to_d;
  logic                toggle_q, toggle_d;
  logic                err_op_q, err_op_d, err_to_q, err_to_d;
  logic                fv_q, fv_d;
`ifdef SERIAL_RX_PARITY_EN
  logic                parity_q, parity_d, err_par_q, err_par_d;
  logic                set_par;
`endif

  logic                ser_edge, ser_bit, expire, set_op, set_to;
  logic [OPCODE_W-1:0] op_next;
  logic [7:0]          len_lu;

  // Stage 3 exists only on the clock path so a rising edge can be detected.
  assign ser_edge = sclk_q[1] & ~sclk_q[2];
  assign ser_bit  = sdat_q[1];
  assign op_next  = {op_q[OPCODE_W-2:0], ser_bit};
  assign len_lu   = LEN_TABLE[8*int'(op_next) +: 8];
  assign expire   = !ser_edge && (to_q == ToW'(TIMEOUT_CYC - 1));

  assign bus.ser_data_thru  = bus.ser_data_in;
  assign bus.ser_clock_thru = bus.ser_clock_in;
  assign bus.data_out       = data_q;
  assign bus.frame_valid    = fv_q;

  // Status word assembly; unused bits read as zero.
  always_comb begin
    bus.status_out             = '0;
    bus.status_out[0]          = toggle_q;
    bus.status_out[OPCODE_W:1] = stat_op_q;
    bus.status_out[30]         = err_op_q;
    bus.status_out[31]         = err_to_q;
`ifdef SERIAL_RX_PARITY_EN
    bus.status_out[29]         = err_par_q;
`endif
  end

  // Pin synchronisers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      sdat_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.ser_clock_in};
      sdat_q <= {sdat_q[0], bus.ser_data_in};
    end
  end

  // Framing FSM next state, shift registers, timeout and register updates.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pay_d     = pay_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    stat_op_d = stat_op_q;
    toggle_d  = toggle_q;
    fv_d      = 1'b0;
    set_op    = 1'b0;
    set_to    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    parity_d  = parity_q;
    set_par   = 1'b0;
`endif

    if (ser_edge) begin
      to_d = '0;
    end else if (state_q == StOpcode || state_q == StPayload || state_q == StDrain
`ifdef SERIAL_RX_PARITY_EN
                 || state_q == StParity
`endif
                 ) begin
      to_d = to_q + ToW'(1);
    end else begin
      to_d = '0;
    end

    unique case (state_q)
      StIdle, StCommit: begin
        if (state_q == StCommit) begin
          if (len_q != 8'd0) data_d = pay_q;
          stat_op_d = op_q;
          toggle_d  = ~toggle_q;
          fv_d      = 1'b1;
          state_d   = StIdle;
        end
        // An edge during commit starts the next frame in the same cycle.
        if (ser_edge) begin
          op_d    = {{(OPCODE_W-1){1'b0}}, ser_bit};
          cnt_d   = CntW'(1);
          state_d = StOpcode;
`ifdef SERIAL_RX_PARITY_EN
          parity_d = ser_bit;
`endif
        end
      end
      StOpcode: begin
        if (ser_edge) begin
          op_d = op_next;
`ifdef SERIAL_RX_PARITY_EN
          parity_d = parity_q ^ ser_bit;
`endif
          if (cnt_q == CntW'(OPCODE_W - 1)) begin
            len_d = len_lu;
            cnt_d = '0;
            pay_d = '0;
            if (!VALID_MASK[op_next]) begin
              set_op  = 1'b1;
              state_d = StDrain;
            end else if (len_lu == 8'd0) begin
`ifdef SERIAL_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StCommit;
`endif
            end else begin
              state_d = StPayload;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (expire) begin
          set_to  = 1'b1;
          state_d = StIdle;
        end
      end
      StPayload: begin
        if (ser_edge) begin
          pay_d = {pay_q[DATA_W-2:0], ser_bit};
          if (cnt_q != CntW'(DATA_W)) cnt_d = cnt_q + CntW'(1);
`ifdef SERIAL_RX_PARITY_EN
          parity_d = parity_q ^ ser_bit;
`endif
          if ((32'(cnt_q) + 32'd1) >= 32'(len_q)) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StCommit;
`endif
          end
        end else if (expire) begin
          set_to  = 1'b1;
          state_d = StIdle;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      StParity: begin
        if (ser_edge) begin
          if (parity_q ^ ser_bit) begin
            set_par = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StCommit;
          end
        end else if (expire) begin
          set_to  = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      StDrain: begin
        // Rejected frame: swallow edges silently until the line goes quiet.
        if (expire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Sticky errors: a new error in the same cycle as err_clear wins.
    err_op_d = set_op | (err_op_q & ~bus.err_clear);
    err_to_d = set_to | (err_to_q & ~bus.err_clear);
`ifdef SERIAL_RX_PARITY_EN
    err_par_d = set_par | (err_par_q & ~bus.err_clear);
`endif
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      pay_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      data_q    <= '0;
      stat_op_q <= '0;
      toggle_q  <= 1'b0;
      err_op_q  <= 1'b0;
      err_to_q  <= 1'b0;
      fv_q      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_q  <= 1'b0;
      err_par_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pay_q     <= pay_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      data_q    <= data_d;
      stat_op_q <= stat_op_d;
      toggle_q  <= toggle_d;
      err_op_q  <= err_op_d;
      err_to_q  <= err_to_d;
      fv_q      <= fv_d;
`ifdef SERIAL_RX_PARITY_EN
      parity_q  <= parity_d;
      err_par_q <= err_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: stimulus pushes expected frames, a monitor pops
// and compares on every frame_valid pulse.
module tb_serial_frame_rx;
  localparam int unsigned DATA_W = 27;

  typedef struct {
    logic [31:0] data;
    logic [31:0] status;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_frames = 0;
  int   n_pushed = 0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

  serial_frame_rx #(
    .OPCODE_W    (4),
    .DATA_W      (DATA_W),
    .LEN_TABLE   (128'h0F),
    .VALID_MASK  (16'h0003),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  // Monitor: every frame_valid cycle must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && bus.frame_valid === 1'b1) begin
      exp_t e;
      n_frames++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame: data=%h status=%h, expected no frame",
                 bus.data_out, bus.status_out);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", 32'(bus.data_out), e.data);
        check("frame_status", bus.status_out, e.status);
      end
    end
  end

  task automatic expect_frame(logic [31:0] data, logic [31:0] status);
    exp_t e;
    e.data   = data;
    e.status = status;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // One serial bit: 4 clocks low with data set up, then 4 clocks high.
  task automatic send_bit(logic b);
    @(posedge clock); #1;
    bus.ser_clock_in = 1'b0;
    bus.ser_data_in  = b;
    repeat (4) @(posedge clock);
    #1 bus.ser_clock_in = 1'b1;
    repeat (4) @(posedge clock);
  endtask

  task automatic send_frame(logic [3:0] op, int len, logic [26:0] pay, logic flip_par);
    for (int i = 3; i >= 0; i--) send_bit(op[i]);
    for (int i = len - 1; i >= 0; i--) send_bit(pay[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^op) ^ (^pay) ^ flip_par);
`else
    if (flip_par) $display("note: parity flip ignored, parity disabled");
`endif
  endtask

  task automatic wait_frames(string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_clear();
    @(posedge clock); #1 bus.err_clear = 1'b1;
    @(posedge clock); #1 bus.err_clear = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset            = 1'b1;
    bus.ser_data_in  = 1'b0;
    bus.ser_clock_in = 1'b0;
    bus.err_clear    = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_data", 32'(bus.data_out), 32'h0);
    check("reset_status", bus.status_out, 32'h0);
    check("reset_valid", 32'(bus.frame_valid), 32'h0);
    bus.ser_data_in = 1'b1;
    #1 check("data_thru", 32'(bus.ser_data_thru), 32'h1);
    bus.ser_clock_in = 1'b1;
    #1 check("clock_thru", 32'(bus.ser_clock_thru), 32'h1);
    bus.ser_data_in  = 1'b0;
    bus.ser_clock_in = 1'b0;
    idle(2000);
    check("idle_no_frames", 32'(n_frames), 32'd0);

    // Opcode 0, 15-bit payload.
    expect_frame(32'h0005A3C, 32'h00000001);
    send_frame(4'h0, 15, 27'h5A3C, 1'b0);
    wait_frames("frame_a_seen");

    // Opcode 1, zero-length payload: data held, toggle back to 0.
    expect_frame(32'h0005A3C, 32'h00000002);
    send_frame(4'h1, 0, 27'h0, 1'b0);
    wait_frames("frame_b_seen");

    // Illegal opcode 7 followed by junk, then quiet line.
    for (int i = 3; i >= 0; i--) send_bit(i < 3);
    for (int i = 0; i < 20; i++) send_bit(i[0]);
    idle(1100);
    check("badop_status", bus.status_out, 32'h40000002);
    check("badop_data", 32'(bus.data_out), 32'h0005A3C);
    check("badop_no_frame", 32'(n_frames), 32'd2);

    expect_frame(32'h0001234, 32'h40000001);
    send_frame(4'h0, 15, 27'h1234, 1'b0);
    wait_frames("frame_c_seen");
    pulse_clear();
    check("clear_badop", bus.status_out, 32'h00000001);

    // Partial payload then timeout.
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    idle(1100);
    check("timeout_status", bus.status_out, 32'h80000001);
    check("timeout_data", 32'(bus.data_out), 32'h0001234);

    expect_frame(32'h0007FFF, 32'h80000000);
    send_frame(4'h0, 15, 27'h7FFF, 1'b0);
    wait_frames("frame_d_seen");
    pulse_clear();
    check("clear_timeout", bus.status_out, 32'h00000000);

`ifdef SERIAL_RX_PARITY_EN
    send_frame(4'h0, 15, 27'h1, 1'b1);
    idle(20);
    check("parity_err_status", bus.status_out, 32'h20000000);
    check("parity_err_data", 32'(bus.data_out), 32'h0007FFF);
    expect_frame(32'h0000001, 32'h20000001);
    send_frame(4'h0, 15, 27'h1, 1'b0);
    wait_frames("frame_par_seen");
`endif

    // Reset in the middle of a frame discards it and clears outputs.
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    @(posedge clock); #1;
    reset            = 1'b1;
    bus.ser_clock_in = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midreset_data", 32'(bus.data_out), 32'h0);
    check("midreset_status", bus.status_out, 32'h0);
    expect_frame(32'h0000ABC, 32'h00000001);
    send_frame(4'h0, 15, 27'h0ABC, 1'b0);
    wait_frames("frame_e_seen");

    idle(20);
    check("frame_count", 32'(n_frames), 32'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
